id_scanner: RTL
===============

# id_scanner

Parametrised lexical scanner and successor to the single-output identifier recogniser. Consumes one ASCII character per accepted cycle. Classifies each delimiter-separated token as identifier, number or error, and reports length and type on a one-cycle token strobe. Also keeps saturating per-type token counters, and exposes the live "prefix is a valid identifier" level as `out`, so the block drops into the existing character-stream front end.

## Interface
- `CHAR_W`, 8: character width; only codes 0–127 are classified, and codes ≥128 are class OTHER.
- `MAX_LEN`, 16: maximum legal token length (≥2).
- `CNT_W`, 8: width of each token counter.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `char` is presented this cycle; the block is always ready.
- `char` input CHAR_W: input character.
- `flush` input 1: end of stream; forces termination of the pending token.
- `clr_cnt` input 1: synchronous clear of all counters.
- `out` output 1: 1 while the characters since the last delimiter form a valid identifier.
- `tok_valid` output 1: one-cycle token-complete strobe.
- `tok_type` output 2: token type, valid with `tok_valid`; 0 = IDENT, 1 = NUMBER, 2 = ERROR.
- `tok_len` output $clog2(MAX_LEN+1): token length excluding the delimiter, valid with `tok_valid`.
- `id_cnt`, `num_cnt`, `err_cnt` output CNT_W each: completed-token counts, saturating.

## Operation
- Character classes:
  - LETTER: A–Z, a–z.
  - DIGIT: 0–9.
  - UNDER: 95.
  - DELIM: 0, 9, 10, 13, 32.
  - OTHER: everything else.
- States are IDLE, IDENT, NUMBER and ERR. Only cycles with `in_valid`=1 advance the FSM.
- IDLE:
  - LETTER or UNDER → IDENT, len=1.
  - DIGIT → NUMBER, len=1.
  - DELIM → IDLE, no emission.
  - OTHER → ERR, len=1.
- IDENT:
  - LETTER, DIGIT or UNDER → IDENT, len+1. If len is already MAX_LEN → ERR instead, len held at MAX_LEN.
  - DELIM → emit IDENT with the current len, then IDLE.
  - OTHER → ERR, len+1 saturating at MAX_LEN.
- NUMBER:
  - DIGIT → NUMBER, len+1; overflow past MAX_LEN → ERR.
  - LETTER or UNDER → ERR (e.g. "9a").
  - DELIM → emit NUMBER, then IDLE.
  - OTHER → ERR.
- ERR:
  - Non-DELIM → ERR, len saturating at MAX_LEN.
  - DELIM → emit ERROR, then IDLE.
- Consecutive delimiters emit nothing.
- `flush`: the token is closed as if a DELIM had been received. If `in_valid` is also high, the character is applied first, so it is included in the token. Exactly one emission occurs even if that character is itself a DELIM. In IDLE, flush emits nothing. The state returns to IDLE.
- Counters:
  - The counter matching `tok_type` increments in the cycle `tok_valid` is driven.
  - Counters saturate at 2^CNT_W−1.
  - When `clr_cnt` coincides with an increment, clear wins and the result is 0.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- `out` is updated the cycle after the character edge. It equals 1 iff the next state is IDENT.
- `tok_valid`, `tok_type` and `tok_len` are valid in the cycle after the delimiter or flush is sampled. `tok_valid` is high for exactly one cycle; `tok_type` and `tok_len` hold their values until the next emission.
- Counter update latency is 1 cycle, coincident with `tok_valid`.
- Asserting `rst_n` mid-token discards the token with no emission and no count. All outputs go to 0 immediately, without waiting for a clock edge.
- Back-to-back tokens, e.g. "a b", produce a strobe every delimiter cycle; throughput is 1 character per cycle.

## Structure
- Package `id_scan_pkg` holds:
  - the ASCII constants: TAB, LF, CR, SPACE, UNDERSCORE, '0', '9', 'A', 'Z', 'a', 'z';
  - the `char_class_t` enum;
  - the `state_t` enum;
  - the `tok_type_t` encoding.
- One combinational sub-module, `id_char_class`, maps `char` to `char_class_t`.
- The top-level contains the FSM, the length register, the output registers and the three counters.

## Test plan
- Inputs 99, 68, 70, 111, 50, 9, one per cycle ("cDFo2\t") → `out`=1 after each of the first five characters; after the tab, `out`=0 and `tok_valid` pulses with IDENT, len 5; `id_cnt`=1.
- Inputs "42 9a " → first strobe NUMBER, len 2; second strobe ERROR, len 2; `num_cnt`=1, `err_cnt`=1; `out` stays 0 throughout.
- MAX_LEN=4 with input "abcde " → `out`=1 for 4 cycles, then 0; strobe ERROR, len 4.
- Input "_x1" followed by `flush` together with `in_valid`=1 and `char`=32 → a single strobe IDENT, len 3; state returns to IDLE.
- CNT_W=2 with five identifiers → `id_cnt` saturates at 3. Then `clr_cnt` asserted in the same cycle as a 6th IDENT strobe → `id_cnt`=0.
- `rst_n` pulled low mid-identifier "ab" → all outputs 0 immediately with no strobe; a following " x " yields IDENT, len 1 with `id_cnt`=1.

Source files
------------

// File: rtl/id_scan_pkg.sv
// Shared constants and types for the lexical scanner: ASCII codes, character
// classes, scanner states and the token type encoding.
package id_scan_pkg;

    localparam logic [6:0] ASC_NUL        = 7'd0;
    localparam logic [6:0] ASC_TAB        = 7'd9;
    localparam logic [6:0] ASC_LF         = 7'd10;
    localparam logic [6:0] ASC_CR         = 7'd13;
    localparam logic [6:0] ASC_SPACE      = 7'd32;
    localparam logic [6:0] ASC_UNDERSCORE = 7'd95;
    localparam logic [6:0] ASC_0          = 7'd48;
    localparam logic [6:0] ASC_9          = 7'd57;
    localparam logic [6:0] ASC_UA         = 7'd65;
    localparam logic [6:0] ASC_UZ         = 7'd90;
    localparam logic [6:0] ASC_LA         = 7'd97;
    localparam logic [6:0] ASC_LZ         = 7'd122;

    typedef enum logic [2:0] {
        CC_LETTER,
        CC_DIGIT,
        CC_UNDER,
        CC_DELIM,
        CC_OTHER
    } char_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IDENT,
        ST_NUMBER,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        TOK_IDENT  = 2'd0,
        TOK_NUMBER = 2'd1,
        TOK_ERROR  = 2'd2
    } tok_type_t;

endpackage

// File: rtl/id_char_class.sv
// Combinational character classifier: maps one input code to its lexical class.
// Codes above 127 are never ASCII and fall into OTHER.
module id_char_class
    import id_scan_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] char,
    output char_class_t       cls
);

    logic [6:0] c7;
    logic       high;

    assign c7   = char[6:0];
    assign high = (char > CHAR_W'(127));

    always_comb begin
        cls = CC_OTHER;
        if (high) begin
            cls = CC_OTHER;
        end else if ((c7 >= ASC_UA && c7 <= ASC_UZ) || (c7 >= ASC_LA && c7 <= ASC_LZ)) begin
            cls = CC_LETTER;
        end else if (c7 >= ASC_0 && c7 <= ASC_9) begin
            cls = CC_DIGIT;
        end else if (c7 == ASC_UNDERSCORE) begin
            cls = CC_UNDER;
        end else if (c7 == ASC_NUL || c7 == ASC_TAB || c7 == ASC_LF ||
                     c7 == ASC_CR  || c7 == ASC_SPACE) begin
            cls = CC_DELIM;
        end
    end

endmodule

// File: rtl/id_scanner.sv
// Lexical scanner: splits a character stream into IDENT / NUMBER / ERROR tokens,
// strobes each completed token with its length and keeps saturating per-type counts.
module id_scanner
    import id_scan_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // in_valid qualifies char for the cycle it is high; there is no ready
    // because a character is accepted on every cycle it is presented.
    input  logic                         in_valid,
    input  logic [CHAR_W-1:0]            char,
    input  logic                         flush,
    input  logic                         clr_cnt,
    output logic                         out,
    output logic                         tok_valid,
    output logic [1:0]                   tok_type,
    output logic [$clog2(MAX_LEN+1)-1:0] tok_len,
    output logic [CNT_W-1:0]             id_cnt,
    output logic [CNT_W-1:0]             num_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [1:0]                   state_dbg
);

    localparam int                LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    char_class_t      cls;
    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n, len_inc;
    logic             emit;
    tok_type_t        emit_type;
    logic [LEN_W-1:0] emit_len;

    id_char_class #(.CHAR_W(CHAR_W)) u_class (
        .char (char),
        .cls  (cls)
    );

    assign len_inc   = (len == LEN_MAX) ? LEN_MAX : len + LEN_ONE;
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        len_n     = len;
        emit      = 1'b0;
        emit_type = TOK_IDENT;
        emit_len  = len;
        if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    case (cls)
                        CC_LETTER, CC_UNDER: begin state_n = ST_IDENT;  len_n = LEN_ONE; end
                        CC_DIGIT:            begin state_n = ST_NUMBER; len_n = LEN_ONE; end
                        CC_OTHER:            begin state_n = ST_ERR;    len_n = LEN_ONE; end
                        default:             ;
                    endcase
                end
                ST_IDENT: begin
                    case (cls)
                        CC_LETTER, CC_DIGIT, CC_UNDER: begin
                            if (len == LEN_MAX) state_n = ST_ERR;
                            else                len_n   = len_inc;
                        end
                        CC_DELIM: begin
                            emit = 1'b1; emit_type = TOK_IDENT;
                            state_n = ST_IDLE; len_n = '0;
                        end
                        default: begin state_n = ST_ERR; len_n = len_inc; end
                    endcase
                end
                ST_NUMBER: begin
                    case (cls)
                        CC_DIGIT: begin
                            if (len == LEN_MAX) state_n = ST_ERR;
                            else                len_n   = len_inc;
                        end
                        CC_DELIM: begin
                            emit = 1'b1; emit_type = TOK_NUMBER;
                            state_n = ST_IDLE; len_n = '0;
                        end
                        default: begin state_n = ST_ERR; len_n = len_inc; end
                    endcase
                end
                default: begin
                    if (cls == CC_DELIM) begin
                        emit = 1'b1; emit_type = TOK_ERROR;
                        state_n = ST_IDLE; len_n = '0;
                    end else begin
                        len_n = len_inc;
                    end
                end
            endcase
        end
        // Flush closes whatever the current character left open; a delimiter
        // that already emitted this cycle suppresses a second strobe.
        if (flush) begin
            if (!emit && state_n != ST_IDLE) begin
                emit     = 1'b1;
                emit_len = len_n;
                case (state_n)
                    ST_IDENT:  emit_type = TOK_IDENT;
                    ST_NUMBER: emit_type = TOK_NUMBER;
                    default:   emit_type = TOK_ERROR;
                endcase
            end
            state_n = ST_IDLE;
            len_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len       <= '0;
            out       <= 1'b0;
            tok_valid <= 1'b0;
            tok_type  <= '0;
            tok_len   <= '0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            out       <= (state_n == ST_IDENT);
            tok_valid <= emit;
            if (emit) begin
                tok_type <= emit_type;
                tok_len  <= emit_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_cnt  <= '0;
            num_cnt <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            id_cnt  <= '0;
            num_cnt <= '0;
            err_cnt <= '0;
        end else if (emit) begin
            case (emit_type)
                TOK_IDENT:  if (id_cnt  != CNT_MAX) id_cnt  <= id_cnt  + CNT_ONE;
                TOK_NUMBER: if (num_cnt != CNT_MAX) num_cnt <= num_cnt + CNT_ONE;
                default:    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
            endcase
        end
    end

endmodule
